// File: rtl/lcd_line_capture.sv
// Captures 2-bit LCD pixels into a line buffer and hands completed lines to a
// double-buffered output register. Optional drop counter: LCD_CAPTURE_DROPCNT_EN.
module lcd_line_capture #(
    parameter int LINE_WIDTH = 160,
    parameter int LINES      = 144
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic                    pix_valid,
    input  logic [1:0]              pix_data,
    output logic                    line_valid,
    input  logic                    line_ready,
    output logic [2*LINE_WIDTH-1:0] line_data,
    output logic [7:0]              line_num,
    output logic                    frame_done,
    output logic                    overflow
`ifdef LCD_CAPTURE_DROPCNT_EN
    ,
    output logic [7:0]              drop_count
`endif
);

    localparam int XW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int YW = (LINES > 1) ? $clog2(LINES) : 1;

    logic [XW-1:0]           x_reg, x_next, x_eff;
    logic [YW-1:0]           y_reg, y_next, y_eff;
    logic [1:0]              capture_reg [LINE_WIDTH];
    logic [LINE_WIDTH-1:0]   write_en;
    logic [2*LINE_WIDTH-1:0] full_line;
    logic                    line_done, last_line, load_out, drop_line;

    logic                    line_valid_reg;
    logic [2*LINE_WIDTH-1:0] line_data_reg;
    logic [7:0]              line_num_reg;
    logic                    frame_done_reg;
    logic                    overflow_reg;

    // frame_start rewinds the counters in the same cycle so a coincident pixel
    // lands in slot 0 of line 0.
    always_comb begin
        x_eff     = frame_start ? '0 : x_reg;
        y_eff     = frame_start ? '0 : y_reg;
        line_done = pix_valid && (x_eff == XW'(LINE_WIDTH - 1));
        last_line = (y_eff == YW'(LINES - 1));
        load_out  = line_done && (!line_valid_reg || line_ready);
        drop_line = line_done && !load_out;
        x_next    = x_eff;
        y_next    = y_eff;
        if (pix_valid) begin
            x_next = line_done ? '0 : x_eff + XW'(1);
        end
        if (line_done) begin
            y_next = last_line ? '0 : y_eff + YW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg <= '0;
            y_reg <= '0;
        end else begin
            x_reg <= x_next;
            y_reg <= y_next;
        end
    end

    // The assembled line bypasses the incoming pixel so the final pixel is
    // included in the copy taken on the completion cycle.
    generate
        for (genvar gi = 0; gi < LINE_WIDTH; gi++) begin : g_slot
            assign write_en[gi] = pix_valid && (x_eff == XW'(gi));
            assign full_line[2*LINE_WIDTH-1-2*gi -: 2] =
                write_en[gi] ? pix_data : capture_reg[gi];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    capture_reg[gi] <= 2'b00;
                end else if (write_en[gi]) begin
                    capture_reg[gi] <= pix_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_valid_reg <= 1'b0;
            line_data_reg  <= '0;
            line_num_reg   <= '0;
            frame_done_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            frame_done_reg <= line_done && last_line;
            if (load_out) begin
                line_valid_reg <= 1'b1;
                line_data_reg  <= full_line;
                line_num_reg   <= 8'(y_eff);
            end else if (line_valid_reg && line_ready) begin
                line_valid_reg <= 1'b0;
            end
            if (drop_line) begin
                overflow_reg <= 1'b1;
            end
        end
    end

`ifdef LCD_CAPTURE_DROPCNT_EN
    logic [7:0] drop_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count_reg <= '0;
        end else if (drop_line && (drop_count_reg != 8'hFF)) begin
            drop_count_reg <= drop_count_reg + 8'd1;
        end
    end

    assign drop_count = drop_count_reg;
`endif

    assign line_valid = line_valid_reg;
    assign line_data  = line_data_reg;
    assign line_num   = line_num_reg;
    assign frame_done = frame_done_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_lcd_line_capture.sv
// Randomized self-checking bench for lcd_line_capture against a line-level
// reference model (pixel arrays and integer counters).
module tb_lcd_line_capture;

    localparam int LW    = 160;
    localparam int LN    = 144;
    localparam int W     = 2 * LW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic          pix_valid = 1'b0;
    logic [1:0]    pix_data = 2'b00;
    logic          line_valid;
    logic          line_ready = 1'b0;
    logic [W-1:0]  line_data;
    logic [7:0]    line_num;
    logic          frame_done;
    logic          overflow;
`ifdef LCD_CAPTURE_DROPCNT_EN
    logic [7:0]    drop_count;
`endif

    lcd_line_capture #(.LINE_WIDTH(LW), .LINES(LN)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .line_valid (line_valid),
        .line_ready (line_ready),
        .line_data  (line_data),
        .line_num   (line_num),
        .frame_done (frame_done),
        .overflow   (overflow)
`ifdef LCD_CAPTURE_DROPCNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        checks_total++;
        if (got === want) checks_passed++;
        else $display("FAIL %s: got %0h want %0h", tag, got, want);
    endtask

    // Reference model: pixel arrays and plain integer counters.
    int       mx, my, m_num, m_drops;
    bit [1:0] m_cap  [LW];
    bit [1:0] m_line [LW];
    bit       m_valid, m_fd, m_ovf;

    function automatic logic [W-1:0] model_line();
        logic [W-1:0] v;
        for (int i = 0; i < LW; i++) v[W-1-2*i -: 2] = m_line[i];
        return v;
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; m_num = 0; m_drops = 0;
        m_valid = 0; m_fd = 0; m_ovf = 0;
        for (int i = 0; i < LW; i++) begin m_cap[i] = 0; m_line[i] = 0; end
    endtask

    task automatic model_clock(input bit fs, input bit pv, input bit [1:0] pd, input bit rdy);
        bit was_valid;
        was_valid = m_valid;
        m_fd = 0;
        if (fs) begin mx = 0; my = 0; end
        if (m_valid && rdy) m_valid = 0;
        if (pv) begin
            m_cap[mx] = pd;
            if (mx == LW - 1) begin
                if (!was_valid || rdy) begin
                    m_valid = 1;
                    m_line  = m_cap;
                    m_num   = my;
                end else begin
                    m_ovf = 1;
                    if (m_drops < 255) m_drops++;
                end
                if (my == LN - 1) begin m_fd = 1; my = 0; end
                else my++;
                mx = 0;
            end else begin
                mx++;
            end
        end
    endtask

    task automatic compare_all();
        check("line_valid", W'(line_valid), W'(m_valid));
        check("line_num",   W'(line_num),   W'(m_num));
        check("line_data",  line_data,      model_line());
        check("frame_done", W'(frame_done), W'(m_fd));
        check("overflow",   W'(overflow),   W'(m_ovf));
`ifdef LCD_CAPTURE_DROPCNT_EN
        check("drop_count", W'(drop_count), W'(m_drops));
`endif
    endtask

    task automatic step(input bit fs, input bit pv, input bit [1:0] pd, input bit rdy);
        frame_start = fs; pix_valid = pv; pix_data = pd; line_ready = rdy;
        @(posedge clk);
        model_clock(fs, pv, pd, rdy);
        #1;
        compare_all();
    endtask

    // Sends one line; values come from mode: 0 const, 1 i%4, 2 random. Optional gaps.
    task automatic send_line(input int mode, input bit [1:0] val, input bit gaps, input bit rdy);
        for (int i = 0; i < LW; i++) begin
            bit [1:0] d;
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) step(0, 0, 2'($urandom), rdy);
            end
            d = (mode == 0) ? val : (mode == 1) ? 2'(i % 4) : 2'($urandom);
            step(0, 1, d, rdy);
        end
    endtask

    int fd_count;
    int frame_lines;

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk) rst = 1'b0;

        // Single line of constant shade 2, consumer always ready.
        step(1, 0, 0, 1);
        send_line(0, 2'b10, 0, 1);
        check("t1_valid", W'(line_valid), W'(1));
        check("t1_data", line_data, {LW{2'b10}});
        check("t1_num", W'(line_num), W'(0));

        // Repeating 0,1,2,3 with random gaps.
        send_line(1, 0, 1, 1);
        check("t2_head", W'(line_data[W-1 -: 8]), W'(8'b00011011));

        // Consumer stalled across three lines: first held, two dropped.
        step(0, 0, 0, 1);
        for (int l = 0; l < 3; l++) send_line(2, 0, 0, 0);
        check("t3_valid", W'(line_valid), W'(1));
        check("t3_ovf", W'(overflow), W'(1));
`ifdef LCD_CAPTURE_DROPCNT_EN
        check("t3_drops", W'(drop_count), W'(2));
`endif
        step(0, 0, 0, 1);

        // Full frame with random consumer stalls kept short enough to drain.
        step(1, 0, 0, 1);
        fd_count = 0;
        for (int l = 0; l < LN; l++) begin
            for (int i = 0; i < LW; i++) begin
                step(0, 1, 2'($urandom), ($urandom_range(0, 3) != 0));
                if (frame_done) fd_count++;
            end
        end
        step(0, 0, 0, 1);
        if (frame_done) fd_count++;
        check("t4_fd_count", W'(fd_count), W'(1));
        send_line(2, 0, 1, 1);
        check("t4_wrap_num", W'(line_num), W'(0));

        // frame_start mid-line 5 discards the partial line.
        step(1, 0, 0, 1);
        for (int l = 0; l < 5; l++) send_line(0, 2'b00, 0, 1);
        for (int i = 0; i < 50; i++) step(0, 1, 2'b11, 1);
        step(1, 1, 2'b01, 1);
        for (int i = 1; i < LW; i++) step(0, 1, 2'b01, 1);
        check("t5_num", W'(line_num), W'(0));
        check("t5_data", line_data, {LW{2'b01}});

        // Asynchronous reset mid-line with a line held pending.
        frame_lines = 3;
        for (int l = 0; l < frame_lines; l++) send_line(2, 0, 0, 0);
        for (int i = 0; i < 30; i++) step(0, 1, 2'($urandom), 0);
        check("t6_pre_valid", W'(line_valid), W'(1));
        #2 rst = 1'b1;
        #1;
        check("t6_async_valid", W'(line_valid), W'(0));
        check("t6_async_ovf", W'(overflow), W'(0));
        model_reset();
        @(negedge clk) rst = 1'b0;
        send_line(2, 0, 1, 1);
        check("t6_num", W'(line_num), W'(0));
        check("t6_valid", W'(line_valid), W'(1));

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
